oam_dma_ctrl: RTL and testbench



---
 rtl/oam_dma_ctrl.sv | 124 ++++++++++++
 tb/tb_oam_dma_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// Purpose: sprite DMA engine; halts the 6502, copies one 256-byte page to the OAM data port, then returns the bus.
// Latency: halt begins the cycle after the trigger write; 513 or 514 halted cycles total depending on the get/put phase.
// Backpressure: none on the system bus (zero-wait memory assumed); the CPU is stalled through cpu_rdy while busy.
module oam_dma_ctrl #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    REG_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_dout,
    input  logic                  cpu_we,
    output logic                  cpu_rdy,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [REG_WIDTH-1:0]  bus_dout,
    output logic                  bus_we,
    input  logic [REG_WIDTH-1:0]  bus_din,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t                state;
    logic [7:0]            page;
    logic [7:0]            idx;
    logic [REG_WIDTH-1:0]  data;
    // parity==0 marks a "get" cycle; reads are only ever placed on those
    logic                  parity;

    logic                  trigger;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] halt_addr;

    assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
    // Source never carries into the next page: idx is only 8 bits wide
    assign src_addr  = ADDR_WIDTH'({page, idx});
    assign halt_addr = ADDR_WIDTH'({page, 8'h00});

    // Sequencer: trigger capture, phase alignment and the read/write copy loop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            data   <= '0;
            parity <= 1'b0;
            done   <= 1'b0;
        end else begin
            parity <= ~parity;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        page  <= cpu_dout[7:0];
                        idx   <= 8'h00;
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
                    // Skip ALIGN when the following cycle is already a get cycle
                    state <= parity ? S_READ : S_ALIGN;
                end
                S_ALIGN: begin
                    state <= S_READ;
                end
                S_READ: begin
                    data  <= bus_din;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx == 8'hFF) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= S_READ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus arbitration: CPU owns the bus in IDLE, the DMA engine everywhere else
    always_comb begin
        busy     = (state != S_IDLE);
        cpu_rdy  = !busy;
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        case (state)
            S_HALT, S_ALIGN: begin
                bus_addr = halt_addr;
                bus_dout = data;
                bus_we   = 1'b0;
            end
            S_READ: begin
                bus_addr = src_addr;
                bus_dout = data;
                bus_we   = 1'b0;
            end
            S_WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = data;
                bus_we   = 1'b1;
            end
            default: begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                bus_we   = cpu_we;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Purpose: self-checking bench for oam_dma_ctrl against a cycle-indexed transfer model.
// Latency: model predicts every output from trigger cycle and clock phase since reset.
// Backpressure: not applicable; memory is an ideal zero-wait function of the address.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic [7:0]  bus_din;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // cycles since reset release; DUT parity equals cyc % 2
    int cyc = 0;

    // model state
    bit          active = 1'b0;
    int          fr = 0;
    int          done_cyc = -1;
    logic [7:0]  m_page = 8'h00;

    // per-transfer observations
    int          halt_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    bit          saw_zero = 1'b0;
    logic [15:0] last_rd = 16'h0;
    logic [7:0]  first_wr = 8'h0;
    logic [7:0]  last_wr = 8'h0;

    oam_dma_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .cpu_rdy  (cpu_rdy),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_we   (bus_we),
        .bus_din  (bus_din),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign bus_din = memf(bus_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Model-based compare on every falling edge, plus observation counters
    always @(negedge clk) begin
        logic        busy_e;
        logic [15:0] addr_e;
        logic        we_e;
        logic [7:0]  dout_e;
        int          rel;
        if (reset) begin
            active   = 1'b0;
            done_cyc = -1;
        end
        busy_e = active && !reset;
        addr_e = cpu_addr;
        we_e   = cpu_we;
        dout_e = cpu_dout;
        if (busy_e) begin
            rel = cyc - fr;
            if (rel < 0) begin
                addr_e = {m_page, 8'h00};
                we_e   = 1'b0;
            end else if (rel % 2 == 0) begin
                addr_e = {m_page, 8'(rel / 2)};
                we_e   = 1'b0;
            end else begin
                addr_e = 16'h2004;
                we_e   = 1'b1;
                dout_e = memf({m_page, 8'((rel - 1) / 2)});
            end
        end
        chk("cpu_rdy", 32'(cpu_rdy), 32'(!busy_e));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("done", 32'(done), 32'(!reset && cyc == done_cyc));
        chk("bus_addr", 32'(bus_addr), 32'(addr_e));
        chk("bus_we", 32'(bus_we), 32'(we_e));
        if (we_e) chk("bus_dout", 32'(bus_dout), 32'(dout_e));

        if (!cpu_rdy) halt_cnt++;
        if (done) done_cnt++;
        if (busy && bus_we && bus_addr == 16'h2004) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wr = bus_dout;
            last_wr = bus_dout;
        end
        if (busy && !bus_we) last_rd = bus_addr;
        if (busy && bus_addr == 16'h0000) saw_zero = 1'b1;

        if (!reset) begin
            if (active && cyc >= fr + 511) begin
                active = 1'b0;
            end else if (!active && cpu_we && cpu_addr == 16'h4014) begin
                active   = 1'b1;
                m_page   = cpu_dout;
                fr       = cyc + ((cyc % 2 == 0) ? 2 : 3);
                done_cyc = fr + 512;
            end
        end
    end

    task automatic start_xfer(input logic [7:0] pg, input int par);
        @(posedge clk); #1;
        if ((cyc % 2) != par) begin
            @(posedge clk); #1;
        end
        halt_cnt = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        saw_zero = 1'b0;
        cpu_addr = 16'h4014;
        cpu_dout = pg;
        cpu_we   = 1'b1;
        @(posedge clk); #1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    task automatic wait_done(input string nm);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < 800 && !fin; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0 && !busy) fin = 1'b1;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within 800 cycles", nm);
        end
    endtask

    task automatic run_xfer(input string nm, input logic [7:0] pg, input int par,
                            input int exp_halt, input bit retrig);
        start_xfer(pg, par);
        if (retrig) begin
            repeat (60) @(posedge clk);
            #1;
            cpu_addr = 16'h4014;
            cpu_dout = 8'h07;
            cpu_we   = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            cpu_we   = 1'b0;
            cpu_addr = 16'h0000;
            cpu_dout = 8'h00;
        end
        wait_done(nm);
        chk({nm, " halt_cycles"}, 32'(halt_cnt), 32'(exp_halt));
        chk({nm, " write_count"}, 32'(wr_cnt), 32'd256);
        chk({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        bit hit;
        reset    = 1'b1;
        cpu_addr = 16'h1234;
        cpu_dout = 8'hA5;
        cpu_we   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bus_addr", 32'(bus_addr), 32'h1234);
        @(posedge clk); #1;
        reset = 1'b0;

        // pass-through write
        @(posedge clk); #1;
        cpu_addr = 16'h0300;
        cpu_dout = 8'h5A;
        cpu_we   = 1'b1;
        #1;
        chk("pt bus_addr", 32'(bus_addr), 32'h0300);
        chk("pt bus_we", 32'(bus_we), 32'd1);
        chk("pt bus_dout", 32'(bus_dout), 32'h5A);
        chk("pt cpu_rdy", 32'(cpu_rdy), 32'd1);
        @(posedge clk); #1;
        cpu_we = 1'b0;

        // even-parity trigger: no ALIGN
        run_xfer("even", 8'h02, 0, 513, 1'b0);
        chk("even first_wr", 32'(first_wr), 32'h3E);
        chk("even last_wr", 32'(last_wr), 32'hC1);

        // odd-parity trigger: one ALIGN cycle
        run_xfer("odd", 8'h02, 1, 514, 1'b0);

        // top page stays inside 0xFF00..0xFFFF
        run_xfer("pgff", 8'hFF, 0, 513, 1'b0);
        chk("pgff last_rd", 32'(last_rd), 32'hFFFF);
        chk("pgff no_zero", 32'(saw_zero), 32'd0);

        // retrigger writes during a transfer are ignored
        run_xfer("retrig", 8'h05, 1, 514, 1'b1);
        chk("retrig first_wr", 32'(first_wr), 32'h39);
        repeat (10) @(posedge clk);
        #1;
        chk("retrig idle", 32'(busy), 32'd0);

        // reset in the middle of a transfer
        start_xfer(8'h04, 0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk); #1;
            if (wr_cnt >= 100) hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL midreset timeout: wr_cnt=%0d never reached 100", wr_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("midreset cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_xfer("after_reset", 8'h03, 0, 513, 1'b0);
        chk("after_reset first_wr", 32'(first_wr), 32'h3F);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
